shmem_responder: RTL and testbench
==================================

Name: shmem_responder

Overview:
- Shared data-memory responder: the memory-side end of the core's store/load interface. The core's MEM stage drives the byte mask, address and write data; this block answers.
- Accepts one request at a time through a valid/ready handshake.
- Commits byte-masked writes into a word-organised RAM.
- Returns read data (or a write acknowledge) after a configurable latency, held until the core takes it.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two ≥ 4.
- BASE_ADDR, 32'h0000_2000, byte address of word 0.
- RD_LATENCY, 1, cycles from the accept edge to rsp_valid; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_we  in  1  1 = write, 0 = read
- req_mask  in  4  byte lanes; bit i selects byte i (bits 8i+7:8i)
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wdata  in  32  write data, already lane-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  core takes the response
- rsp_rdata  out  32  read word; 0 for writes and errors
- rsp_err  out  1  address out of range, or parity fault when enabled

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - req_ready=0 while rst is high.
  - RAM contents are NOT cleared.
  - Reset mid-operation drops the pending response. A write already accepted stays committed.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Accept when req_valid && req_ready at an edge. At accept, latch we, word index, range flag and read word, then load counter = RD_LATENCY-1. If RD_LATENCY==1 go to RESP, else go to WAIT.
  - WAIT: req_ready=0. Decrement the counter each cycle; when counter==1, go to RESP on the next edge.
  - RESP: rsp_valid=1, outputs stable. On rsp_valid && rsp_ready go to IDLE. rsp_valid, rsp_rdata and rsp_err clear on that same edge. Back-to-back requests are therefore separated by one IDLE cycle.
- Latency: rsp_valid is first high exactly RD_LATENCY cycles after the accept edge.
- Address decode:
  - offset = req_addr - BASE_ADDR; index = offset[31:2].
  - In range iff req_addr ≥ BASE_ADDR and index < DEPTH.
  - Out of range: no RAM access, rsp_rdata=0, rsp_err=1.
- Writes:
  - Byte i is written at the accept edge iff req_mask[i]; other bytes are unchanged.
  - req_mask=0 is a legal no-op that still responds with rsp_err=0.
  - Write response: rsp_rdata=0.
- Reads:
  - Return the full 32-bit word; req_mask is ignored because the LSU extracts lanes.
  - Data reflects all writes accepted before the read's accept edge (a single outstanding request means no hazard).
- req_* inputs are don't-care outside the accept edge.
- Address wrap: 32-bit subtraction. An address below BASE_ADDR underflows to a large offset and is out of range.

Optional Feature:
- Macro: SHMEM_PARITY_EN.
- Defined:
  - Each byte stores an extra even-parity bit, computed on write.
  - A read recomputes parity on all 4 bytes. Any mismatch gives rsp_err=1, and rsp_rdata still carries the raw word.
  - An extra input port parity_inject (1 bit) flips the stored parity of every written byte when high at the write's accept edge, for verification.
- Not defined: no parity storage, no parity_inject port, rsp_err reflects range only.

Test Plan:
- Reset then idle: hold rst 3 cycles -> rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0 during rst and 1 the cycle after.
- Full write then read (RD_LATENCY=1): write 32'hDEADBEEF to 32'h2004, mask 4'hF, rsp_ready=1 -> rsp_valid 1 cycle later, rsp_rdata=0, rsp_err=0. Read 32'h2004 -> rsp_rdata=32'hDEADBEEF.
- Byte-masked merge: after the previous test, write 32'h0000_5500, mask 4'b0010 to 32'h2004 -> read gives 32'hDEAD55EF. Write with mask 4'h0 -> read unchanged.
- Latency and backpressure (RD_LATENCY=3): read accepted at cycle 10 -> rsp_valid first high at cycle 13. Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout. Raise rsp_ready -> IDLE next cycle.
- Range errors:
  - Read 32'h1FFC -> rsp_err=1, rdata=0.
  - Write 32'h2000+4*DEPTH -> rsp_err=1, no word modified (word 0 and word DEPTH-1 unchanged).
  - Read 32'h2000+4*(DEPTH-1) -> rsp_err=0.
- Reset mid-operation (RD_LATENCY=3): write 32'h12345678 to 32'h2008, assert rst in WAIT -> no rsp_valid. After release, read 32'h2008 -> 32'h12345678. With SHMEM_PARITY_EN: write with parity_inject=1, then read -> rsp_err=1, rdata equal to the written word.

Source files
------------

// File: rtl/shmem_responder_if.sv
// Request/response bundle between the core's MEM stage (master) and the shared data memory (slave).
interface shmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_mask;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_mask, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_mask, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/shmem_responder.sv
// Shared data-memory responder: one outstanding byte-masked request, response after RD_LATENCY cycles.
// Optional per-byte even parity with fault injection when SHMEM_PARITY_EN is defined.
module shmem_responder #(
    parameter int unsigned DEPTH      = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
`ifdef SHMEM_PARITY_EN
    input  logic parity_inject,
`endif
    shmem_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [1:0]    r_latCnt;
    logic [1:0]    w_nextCnt;
    logic [31:0]   r_rspData;
    logic          r_rspErr;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic [31:0]   w_offset;
    logic [31:0]   w_index;
    logic          w_inRange;
    logic [AW-1:0] w_wordAddr;
    logic [31:0]   w_rdWord;
    logic          w_parFault;

    // Addresses below BASE_ADDR wrap to a huge offset and fall out of range naturally.
    assign w_offset   = bus.req_addr - BASE_ADDR;
    assign w_index    = w_offset >> 2;
    assign w_inRange  = (bus.req_addr >= BASE_ADDR) && (w_index < 32'(DEPTH));
    assign w_wordAddr = w_index[AW-1:0];
    assign w_rdWord   = r_mem[w_wordAddr];

    always_ff @(posedge clk) begin
        if (w_accept && bus.req_we && w_inRange) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_mask[i]) begin
                    r_mem[w_wordAddr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef SHMEM_PARITY_EN
    logic [3:0] r_par [DEPTH];
    logic [3:0] w_wrPar;

    always_comb begin
        w_wrPar    = '0;
        w_parFault = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_wrPar[i] = (^bus.req_wdata[8*i +: 8]) ^ parity_inject;
            if ((^w_rdWord[8*i +: 8]) != r_par[w_wordAddr][i]) begin
                w_parFault = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && bus.req_we && w_inRange) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_mask[i]) begin
                    r_par[w_wordAddr][i] <= w_wrPar[i];
                end
            end
        end
    end
`else
    assign w_parFault = 1'b0;
`endif

    always_comb begin
        w_nextState   = r_state;
        w_nextCnt     = r_latCnt;
        w_accept      = 1'b0;
        bus.req_ready = 1'b0;
        case (r_state)
            IDLE: begin
                bus.req_ready = !rst;
                if (bus.req_valid && !rst) begin
                    w_accept  = 1'b1;
                    w_nextCnt = 2'(RD_LATENCY - 1);
                    if (RD_LATENCY == 1) begin
                        w_nextState = RESP;
                    end else begin
                        w_nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                w_nextCnt = r_latCnt - 2'd1;
                if (r_latCnt == 2'd1) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The whole response is captured at accept; RESP only gates it onto the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_latCnt  <= '0;
            r_rspData <= '0;
            r_rspErr  <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_latCnt <= w_nextCnt;
            if (w_accept) begin
                r_rspData <= (!bus.req_we && w_inRange) ? w_rdWord : 32'd0;
                r_rspErr  <= !w_inRange || (!bus.req_we && w_parFault);
            end
        end
    end

    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = bus.rsp_valid ? r_rspData : 32'd0;
    assign bus.rsp_err   = bus.rsp_valid && r_rspErr;
endmodule

// File: tb/tb_shmem_responder.sv
// Randomised bench: two responders (latency 1 and 3) checked against a byte-array memory model.
module tb_shmem_responder;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit          tbSel      = 1'b0;
    logic        tbValid    = 1'b0;
    logic        tbWe       = 1'b0;
    logic [3:0]  tbMask     = 4'h0;
    logic [31:0] tbAddr     = 32'h0;
    logic [31:0] tbWdata    = 32'h0;
    logic        tbRspReady = 1'b0;
    logic        parInject  = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] memModel [2][DEPTH][4];
    bit         badPar   [2][DEPTH][4];

    shmem_responder_if bus1();
    shmem_responder_if bus3();

    assign bus1.req_valid = tbValid && (tbSel == 1'b0);
    assign bus1.req_we    = tbWe;
    assign bus1.req_mask  = tbMask;
    assign bus1.req_addr  = tbAddr;
    assign bus1.req_wdata = tbWdata;
    assign bus1.rsp_ready = tbRspReady && (tbSel == 1'b0);
    assign bus3.req_valid = tbValid && (tbSel == 1'b1);
    assign bus3.req_we    = tbWe;
    assign bus3.req_mask  = tbMask;
    assign bus3.req_addr  = tbAddr;
    assign bus3.req_wdata = tbWdata;
    assign bus3.rsp_ready = tbRspReady && (tbSel == 1'b1);

    logic        obsReady, obsValid, obsErr;
    logic [31:0] obsRdata;
    assign obsReady = tbSel ? bus3.req_ready : bus1.req_ready;
    assign obsValid = tbSel ? bus3.rsp_valid : bus1.rsp_valid;
    assign obsErr   = tbSel ? bus3.rsp_err   : bus1.rsp_err;
    assign obsRdata = tbSel ? bus3.rsp_rdata : bus1.rsp_rdata;

    shmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LATENCY(1)) dut1 (
        .clk(clk),
        .rst(rst),
`ifdef SHMEM_PARITY_EN
        .parity_inject(parInject),
`endif
        .bus(bus1)
    );

    shmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LATENCY(3)) dut3 (
        .clk(clk),
        .rst(rst),
`ifdef SHMEM_PARITY_EN
        .parity_inject(parInject),
`endif
        .bus(bus3)
    );

    function automatic bit addrInRange(input logic [31:0] addr);
        longint a;
        a = longint'(addr);
        return (a >= longint'(BASE)) && ((a - longint'(BASE)) < longint'(4 * DEPTH));
    endfunction

    // Applies a request to the model and returns the response the core should see.
    function automatic void modelTxn(input bit s, input bit we, input logic [3:0] mask,
                                     input logic [31:0] addr, input logic [31:0] wdata, input bit inj,
                                     output logic [31:0] expData, output logic expErr);
        int idx;
        expData = 32'h0;
        expErr  = 1'b0;
        if (!addrInRange(addr)) begin
            expErr = 1'b1;
            return;
        end
        idx = int'((addr - BASE) / 4);
        for (int i = 0; i < 4; i++) begin
            if (we) begin
                if (mask[i]) begin
                    memModel[s][idx][i] = wdata[8*i +: 8];
                    badPar[s][idx][i]   = inj;
                end
            end else begin
                expData[8*i +: 8] = memModel[s][idx][i];
                if (badPar[s][idx][i]) expErr = 1'b1;
            end
        end
    endfunction

    function automatic int expLat(input bit s);
        return s ? 3 : 1;
    endfunction

    // Runs one request/response; entered and left just after a falling edge.
    task automatic doTxn(input bit s, input bit we, input logic [3:0] mask, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output bit stable, output logic validAfter, output logic readyAfter,
                         output bit timedOut);
        int guard;
        timedOut   = 1'b0;
        stable     = 1'b1;
        rdata      = 32'h0;
        err        = 1'b0;
        lat        = 0;
        validAfter = 1'b0;
        readyAfter = 1'b0;
        tbSel      = s;
        #1;
        guard = 0;
        while (!obsReady && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!obsReady) begin
            timedOut = 1'b1;
            return;
        end
        tbWe = we; tbMask = mask; tbAddr = addr; tbWdata = wdata;
        tbValid = 1'b1; tbRspReady = 1'b0;
        @(posedge clk);
        #1;
        tbValid = 1'b0;
        tbWe = 1'($urandom); tbMask = 4'($urandom); tbAddr = $urandom; tbWdata = $urandom;
        for (lat = 1; lat <= 10; lat++) begin
            @(negedge clk);
            if (obsValid) break;
        end
        if (!obsValid) begin
            timedOut = 1'b1;
            return;
        end
        rdata = obsRdata;
        err   = obsErr;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (obsValid !== 1'b1 || obsRdata !== rdata || obsErr !== err || obsReady !== 1'b0)
                stable = 1'b0;
        end
        tbRspReady = 1'b1;
        @(negedge clk);
        validAfter = obsValid;
        readyAfter = obsReady;
        tbRspReady = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            compared++;
            if ({bus1.req_ready, bus3.req_ready, bus1.rsp_valid, bus3.rsp_valid,
                 bus1.rsp_err, bus3.rsp_err} !== 6'b0 || bus1.rsp_rdata !== 32'h0 || bus3.rsp_rdata !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL reset_hold: got ready=%b%b valid=%b%b err=%b%b rdata=%h/%h, expected all zero",
                         bus1.req_ready, bus3.req_ready, bus1.rsp_valid, bus3.rsp_valid,
                         bus1.rsp_err, bus3.rsp_err, bus1.rsp_rdata, bus3.rsp_rdata);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (bus1.req_ready !== 1'b1 || bus3.req_ready !== 1'b1 || bus1.rsp_valid !== 1'b0 || bus3.rsp_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_release: got ready=%b%b valid=%b%b, expected ready=11 valid=00",
                     bus1.req_ready, bus3.req_ready, bus1.rsp_valid, bus3.rsp_valid);
        end
    endtask

    task automatic test_init_fill();
        logic [31:0] rd, expD, data;
        logic        er, expE, va, ra;
        int          lat;
        bit          st, to;
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < DEPTH; w++) begin
                data = $urandom;
                modelTxn(1'(s), 1'b1, 4'hF, BASE + 32'(4 * w), data, 1'b0, expD, expE);
                doTxn(1'(s), 1'b1, 4'hF, BASE + 32'(4 * w), data, 0, rd, er, lat, st, va, ra, to);
                compared++;
                if (to || rd !== expD || er !== expE || lat != expLat(1'(s))) begin
                    mismatched++;
                    $display("[TB] FAIL init_write s=%0d w=%0d: got rdata=%h err=%b lat=%0d timeout=%b, expected %h/%b/%0d/0",
                             s, w, rd, er, lat, to, expD, expE, expLat(1'(s)));
                end
            end
        end
    endtask

    task automatic test_full_write_read();
        logic [31:0] rd, expD;
        logic        er, expE, va, ra;
        int          lat;
        bit          st, to;
        modelTxn(1'b0, 1'b1, 4'hF, 32'h2004, 32'hDEADBEEF, 1'b0, expD, expE);
        doTxn(1'b0, 1'b1, 4'hF, 32'h2004, 32'hDEADBEEF, 0, rd, er, lat, st, va, ra, to);
        compared++;
        if (to || lat != 1 || rd !== 32'h0 || er !== 1'b0 || va !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL full_write: got lat=%0d rdata=%h err=%b validAfter=%b timeout=%b, expected 1/00000000/0/0/0",
                     lat, rd, er, va, to);
        end
        doTxn(1'b0, 1'b0, 4'h0, 32'h2004, 32'h0, 0, rd, er, lat, st, va, ra, to);
        compared++;
        if (to || rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 1) begin
            mismatched++;
            $display("[TB] FAIL full_read: got rdata=%h err=%b lat=%0d, expected deadbeef/0/1", rd, er, lat);
        end
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd, expD;
        logic        er, expE, va, ra;
        int          lat;
        bit          st, to;
        modelTxn(1'b0, 1'b1, 4'b0010, 32'h2004, 32'h0000_5500, 1'b0, expD, expE);
        doTxn(1'b0, 1'b1, 4'b0010, 32'h2004, 32'h0000_5500, 0, rd, er, lat, st, va, ra, to);
        doTxn(1'b0, 1'b0, 4'hF, 32'h2004, 32'h0, 0, rd, er, lat, st, va, ra, to);
        compared++;
        if (to || rd !== 32'hDEAD55EF || er !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL byte_merge: got rdata=%h err=%b, expected dead55ef/0", rd, er);
        end
        doTxn(1'b0, 1'b1, 4'h0, 32'h2004, 32'hFFFF_FFFF, 0, rd, er, lat, st, va, ra, to);
        compared++;
        if (to || er !== 1'b0 || rd !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL zero_mask_write: got rdata=%h err=%b, expected 00000000/0", rd, er);
        end
        doTxn(1'b0, 1'b0, 4'h0, 32'h2004, 32'h0, 0, rd, er, lat, st, va, ra, to);
        compared++;
        if (to || rd !== 32'hDEAD55EF || er !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL zero_mask_read: got rdata=%h err=%b, expected dead55ef/0", rd, er);
        end
    endtask

    task automatic test_latency_backpressure();
        logic [31:0] rd, expD;
        logic        er, expE, va, ra;
        int          lat;
        bit          st, to;
        modelTxn(1'b1, 1'b0, 4'h0, BASE + 32'd20, 32'h0, 1'b0, expD, expE);
        doTxn(1'b1, 1'b0, 4'h0, BASE + 32'd20, 32'h0, 5, rd, er, lat, st, va, ra, to);
        compared++;
        if (to || lat != 3) begin
            mismatched++;
            $display("[TB] FAIL latency3: got lat=%0d timeout=%b, expected 3/0", lat, to);
        end
        compared++;
        if (!st || rd !== expD || er !== expE) begin
            mismatched++;
            $display("[TB] FAIL backpressure_hold: got stable=%b rdata=%h err=%b, expected 1/%h/%b", st, rd, er, expD, expE);
        end
        compared++;
        if (va !== 1'b0 || ra !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL backpressure_release: got valid=%b ready=%b, expected 0/1", va, ra);
        end
    endtask

    task automatic test_range_errors();
        logic [31:0] rd, expD, data;
        logic        er, expE, va, ra;
        int          lat;
        bit          st, to;
        logic [31:0] addrs [5];
        bit          wes   [5];
        addrs = '{32'h1FFC, BASE + 32'(4 * DEPTH), BASE, BASE + 32'(4 * (DEPTH - 1)), 32'hFFFF_FFFF};
        wes   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            data = $urandom;
            modelTxn(1'b0, wes[k], 4'hF, addrs[k], data, 1'b0, expD, expE);
            doTxn(1'b0, wes[k], 4'hF, addrs[k], data, 0, rd, er, lat, st, va, ra, to);
            compared++;
            if (to || rd !== expD || er !== expE) begin
                mismatched++;
                $display("[TB] FAIL range addr=%h we=%b: got rdata=%h err=%b timeout=%b, expected %h/%b",
                         addrs[k], wes[k], rd, er, to, expD, expE);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, expD, data, addr;
        logic [3:0]  mask;
        logic        er, expE, va, ra;
        int          lat, hold, pick;
        bit          st, to, s, we;
        for (int n = 0; n < 60; n++) begin
            s    = 1'($urandom);
            we   = 1'($urandom);
            mask = 4'($urandom);
            data = $urandom;
            hold = $urandom_range(0, 3);
            pick = $urandom_range(0, 19);
            if (pick < 16)       addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            else if (pick == 16) addr = BASE - 32'(4 * $urandom_range(1, 8));
            else if (pick == 17) addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
            else                 addr = $urandom;
            modelTxn(s, we, mask, addr, data, 1'b0, expD, expE);
            doTxn(s, we, mask, addr, data, hold, rd, er, lat, st, va, ra, to);
            compared++;
            if (to || rd !== expD || er !== expE) begin
                mismatched++;
                $display("[TB] FAIL random_rsp n=%0d s=%0d we=%b addr=%h: got rdata=%h err=%b timeout=%b, expected %h/%b",
                         n, s, we, addr, rd, er, to, expD, expE);
            end
            compared++;
            if (lat != expLat(s) || !st || va !== 1'b0 || ra !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL random_timing n=%0d s=%0d: got lat=%0d stable=%b validAfter=%b readyAfter=%b, expected %0d/1/0/1",
                         n, s, lat, st, va, ra, expLat(s));
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd, expD;
        logic        er, expE, va, ra;
        int          lat, guard;
        bit          st, to, sawValid;
        tbSel = 1'b1;
        #1;
        guard = 0;
        while (!bus3.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        tbWe = 1'b1; tbMask = 4'hF; tbAddr = BASE + 32'd8; tbWdata = 32'h12345678; tbValid = 1'b1;
        @(posedge clk);
        #1;
        tbValid = 1'b0;
        modelTxn(1'b1, 1'b1, 4'hF, BASE + 32'd8, 32'h12345678, 1'b0, expD, expE);
        @(negedge clk);
        rst = 1'b1;
        sawValid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus3.rsp_valid !== 1'b0) sawValid = 1'b1;
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus3.rsp_valid !== 1'b0) sawValid = 1'b1;
        end
        compared++;
        if (sawValid) begin
            mismatched++;
            $display("[TB] FAIL midop_reset_drop: got a response after reset, expected none");
        end
        doTxn(1'b1, 1'b0, 4'h0, 32'h2008, 32'h0, 0, rd, er, lat, st, va, ra, to);
        compared++;
        if (to || rd !== 32'h12345678 || er !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midop_write_kept: got rdata=%h err=%b timeout=%b, expected 12345678/0", rd, er, to);
        end
`ifdef SHMEM_PARITY_EN
        parInject = 1'b1;
        modelTxn(1'b1, 1'b1, 4'hF, 32'h200C, 32'hA5C3_0F81, 1'b1, expD, expE);
        doTxn(1'b1, 1'b1, 4'hF, 32'h200C, 32'hA5C3_0F81, 0, rd, er, lat, st, va, ra, to);
        parInject = 1'b0;
        modelTxn(1'b1, 1'b0, 4'h0, 32'h200C, 32'h0, 1'b0, expD, expE);
        doTxn(1'b1, 1'b0, 4'h0, 32'h200C, 32'h0, 0, rd, er, lat, st, va, ra, to);
        compared++;
        if (to || rd !== 32'hA5C3_0F81 || er !== 1'b1 || er !== expE) begin
            mismatched++;
            $display("[TB] FAIL parity_inject: got rdata=%h err=%b, expected a5c30f81/1", rd, er);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_init_fill();
        test_full_write_read();
        test_byte_merge();
        test_latency_backpressure();
        test_range_errors();
        test_random();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
